comparador_serial_ctrl: RTL
===========================

# comparador_serial_ctrl

Bit-serial magnitude comparator controller for the iterative-network design. It owns one instance of the typical cell `celda_tipica_e` and sequences it over an N-bit operand pair, one bit per clock, from LSB to MSB (right to left). The cell output is registered as the next carry `w`. The block gives a one-cell, area-minimal alternative to the fully unrolled combinational network and exposes a start/busy/done handshake to the surrounding control logic.

## Interface
- `N`, default 8: operand width in bits; legal range is N ≥ 2.
- `CNT_W`, localparam `$clog2(N)`: width of the bit counter. Not overridable.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a comparison; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of the operation in progress.
- `ge_mode`  in  1  seed for `w`: 0 gives A>B, 1 gives A≥B; captured with `start`.
- `a_in`  in  N  operand A; captured with `start`.
- `b_in`  in  N  operand B; captured with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  1  last completed comparison; held until the next completion.

## Operation
- Cell function, applied each RUN cycle: `w_next = A·!B + w·A + w·!B`, where A is `a_sh[0]` and B is `b_sh[0]`.
- **IDLE.** When `start`=1:
  - load `a_sh←a_in`, `b_sh←b_in`, `w←ge_mode`, `cnt←0`;
  - go to RUN.
- **RUN.** Each edge:
  - `w←w_next`;
  - shift `a_sh` and `b_sh` right by 1, zero fill;
  - `cnt←cnt+1`.
  - When `cnt==N-1`, instead: `result←w_next`, `cnt←0`, go to DONE.
- **DONE.** `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. There is no queuing.
- `abort`=1 in RUN or DONE: go to IDLE on the next edge, `done` is not pulsed, `result` is unchanged. `abort` has priority over the `cnt==N-1` completion and over the DONE→IDLE transition. It has no effect in IDLE.
- If `start` and `abort` are both high in IDLE, `start` wins.
- Operand inputs may change freely after the capture edge.
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `w`=0, `cnt`=0, shift registers=0. Reset may be applied at any point, including mid-RUN, and returns the block to these values immediately.
- Outputs are decoded from registered state only; there are no combinational input-to-output paths.

## Timing
- Capture edge E0 is the edge where `start` is seen high in IDLE.
- RUN occupies N cycles, E0+1 … E0+N. Bit i is evaluated at edge E0+1+i.
- DONE is entered at E0+N. `done` and the new `result` are visible during the cycle E0+N … E0+N+1.
- `busy` rises after E0 and falls after E0+N+1.
- Earliest next capture is at edge E0+N+2, so throughput is one comparison per N+2 cycles.
- The counter never wraps. `cnt` is compared against N-1 and cleared on the DONE transition.

## Structure
- Shared header `red_iterativa_defs.vh` holds:
  - state encodings `ST_IDLE=2'd0`, `ST_RUN=2'd1`, `ST_DONE=2'd2` (value 3 is illegal and recovers to IDLE);
  - comparison-mode constants `MODE_GT=1'b0`, `MODE_GE=1'b1`.
- One sub-module: the existing `celda_tipica_e` cell, instantiated once, with inputs `a_sh[0]`, `b_sh[0]`, `w` and output `w_next`.
- All other logic (FSM, counter, shift registers, `w` and `result` registers) stays in this module.

## Test plan
- N=8, A=0x5A, B=0x3C, `ge_mode`=0, pulse `start` → `done` pulses 8 cycles after capture with `result`=1; `busy` is high for 9 cycles.
- A=B=0x77: with `ge_mode`=0 → `result`=0; repeat with `ge_mode`=1 → `result`=1.
- A=0x80, B=0x7F → `result`=1. Then A=0x00, B=0xFF → `result`=0. Both cases check MSB dominance over the lower bits.
- Hold `start` high and change `a_in` throughout RUN → only the first capture counts, the result matches the first operands, and the next capture happens at E0+N+2.
- `abort` at E0+4 → IDLE next cycle, no `done` pulse, `result` keeps its previous value. Also drive `abort` together with the `cnt==N-1` edge → no completion.
- Deassert `rst_n` asynchronously mid-RUN → `busy`, `done` and `result` go to 0 immediately. After release, a fresh `start` completes correctly.

Source files
------------

// File: rtl/comparador_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encodings, comparison-mode seeds and the typical-cell function.
`default_nettype none

package comparador_serial_ctrl_pkg;

  // Encoding 2'd3 is not a real state; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  localparam logic MODE_GT = 1'b0;
  localparam logic MODE_GE = 1'b1;

  // Carry to the next (more significant) position: set when A>B at this bit,
  // or when the bits tie and the lower bits already decided in favour of A.
  function automatic logic cell_fn(input logic a, input logic b, input logic w);
    return (a & ~b) | (w & a) | (w & ~b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/comparador_serial_ctrl_celda.sv
// Typical cell of the iterative comparator network: one bit position,
// combinational carry from the less significant side to the more significant one.
`default_nettype none

module celda_tipica_e
  import comparador_serial_ctrl_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic w_i,
  output logic w_o
);

  assign w_o = cell_fn(a_i, b_i, w_i);

endmodule

`default_nettype wire

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial magnitude comparator controller: one typical cell reused LSB to MSB,
// with a start/busy/done handshake and synchronous abort.
`default_nettype none

module comparador_serial_ctrl
  import comparador_serial_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         ge_mode,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic         result
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q;
  logic [N-1:0]     a_sh_q;
  logic [N-1:0]     b_sh_q;
  logic             w_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             result_q;

  logic             w_d;
  logic [CNT_W-1:0] cnt_d;

  celda_tipica_e u_celda (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .w_i (w_q),
    .w_o (w_d)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      w_q      <= MODE_GT;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // start outranks abort here; abort has no meaning while idle
          if (start) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            w_q     <= ge_mode;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (abort) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            w_q    <= w_d;
            a_sh_q <= {1'b0, a_sh_q[N-1:1]};
            b_sh_q <= {1'b0, b_sh_q[N-1:1]};
            if (cnt_q == CNT_LAST) begin
              result_q <= w_d;
              cnt_q    <= '0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          cnt_q   <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire
